pc_fetch_ctrl: RTL and testbench

//  Owns the program counter and the IF-stage fetch handshake. Consumes resolved

---
 rtl/pc_fetch_ctrl_if.sv | 32 +++
 rtl/pc_fetch_ctrl.sv | 161 ++++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_ctrl_if.sv
// rtl/pc_fetch_ctrl_if.sv - instruction memory fetch bus between IF stage and imem
//
// Purpose: carries one fetch request/response handshake.
// Signals:
//   imem_req    master->slave  fetch request, held until imem_ready
//   imem_addr   master->slave  word-aligned fetch address, stable while pending
//   imem_ready  slave->master  response valid; completes the current request
//   imem_rdata  slave->master  instruction word returned with imem_ready
// Modports:
//   master  fetch controller side
//   slave   instruction memory side

interface pc_fetch_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - program counter and IF-stage fetch handshake controller
//
// Purpose: owns the PC, issues instruction fetches, accepts redirects from EX,
// drains an in-flight fetch made stale by a redirect, and hands (pc, instr)
// pairs to the IF/ID register.
// Parameters:
//   RESET_PC        PC loaded on reset
// Ports:
//   clk             system clock, rising edge
//   rst             synchronous reset, active-high
//   stall_i         hold the PC and do not hand off a completed fetch
//   redir_valid_i   redirect taken this cycle
//   redir_target_i  redirect target address
//   imem            fetch bus (master modport): req/addr out, ready/rdata in
//   if_valid_o      if_pc_o/if_instr_o valid for IF/ID (registered)
//   if_pc_o         PC of the delivered instruction
//   if_instr_o      delivered instruction word
//   flush_o         kill IF/ID contents this cycle (combinational)
//   misalign_o      one-cycle pulse: accepted redirect target had [1:0] != 0
//   pc_o            current PC

module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall_i,
    input  logic                   redir_valid_i,
    input  logic [31:0]            redir_target_i,
    pc_fetch_ctrl_if.master        imem,
    output logic                   if_valid_o,
    output logic [31:0]            if_pc_o,
    output logic [31:0]            if_instr_o,
    output logic                   flush_o,
    output logic                   misalign_o,
    output logic [31:0]            pc_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pending_q, pending_d;
    logic        if_valid_q, if_valid_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic [31:0] if_instr_q, if_instr_d;
    logic        misalign_q, misalign_d;
    logic        req;

    // Targets are forced onto a word boundary; the low bits only feed the
    // misalign pulse.
    logic [31:0] redir_aligned;
    logic        redir_misaligned;

    assign redir_aligned    = {redir_target_i[31:2], 2'b00};
    assign redir_misaligned = |redir_target_i[1:0];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            pending_q  <= 32'h0000_0000;
            if_valid_q <= 1'b0;
            if_pc_q    <= 32'h0000_0000;
            if_instr_q <= 32'h0000_0000;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pending_q  <= pending_d;
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
            misalign_q <= misalign_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pending_d  = pending_q;
        if_valid_d = 1'b0;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        misalign_d = 1'b0;
        req        = 1'b0;

        case (state_q)
            S_IDLE: begin
                // One quiet cycle after reset before the first request.
                state_d = S_FETCH;
            end

            S_FETCH: begin
                req = 1'b1;
                if (redir_valid_i) begin
                    // Redirect wins over stall and over a completing fetch.
                    misalign_d = redir_misaligned;
                    if (imem.imem_ready) begin
                        // Response belongs to the wrong path: drop it.
                        pc_d = redir_aligned;
                    end else begin
                        // The request must finish at its current address before
                        // the PC may move, so park the target.
                        pending_d = redir_aligned;
                        state_d   = S_DRAIN;
                    end
                end else if (imem.imem_ready && !stall_i) begin
                    if_valid_d = 1'b1;
                    if_pc_d    = pc_q;
                    if_instr_d = imem.imem_rdata;
                    pc_d       = pc_q + 32'd4;
                end
                // Stalled ready responses fall through: PC holds, and the same
                // address is simply fetched again once the stall lifts.
            end

            S_DRAIN: begin
                req = 1'b1;
                if (redir_valid_i) begin
                    // Latest redirect wins.
                    pending_d  = redir_aligned;
                    misalign_d = redir_misaligned;
                end
                if (imem.imem_ready) begin
                    // Stale response completes; discard it and jump.
                    pc_d    = redir_valid_i ? redir_aligned : pending_q;
                    state_d = S_FETCH;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign imem.imem_req  = req;
    assign imem.imem_addr = pc_q;

    assign flush_o    = !rst && redir_valid_i && (state_q != S_IDLE);
    assign if_valid_o = if_valid_q;
    assign if_pc_o    = if_pc_q;
    assign if_instr_o = if_instr_q;
    assign misalign_o = misalign_q;
    assign pc_o       = pc_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - directed self-checking bench for pc_fetch_ctrl

module tb_pc_fetch_ctrl;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redir_v;
    logic [31:0] redir_t;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        flush;
    logic        misalign;
    logic [31:0] pc;

    logic        rst2;
    logic        stall2;
    logic        redir_v2;
    logic [31:0] redir_t2;
    logic        if_valid2;
    logic [31:0] if_pc2;
    logic [31:0] if_instr2;
    logic        flush2;
    logic        misalign2;
    logic [31:0] pc2;

    int pass_cnt;
    int total_cnt;

    pc_fetch_ctrl_if bus ();
    pc_fetch_ctrl_if bus2 ();

    // Memory model: instruction word is a fixed function of its address.
    assign bus.imem_rdata  = bus.imem_addr ^ KEY;
    assign bus2.imem_rdata = bus2.imem_addr ^ KEY;

    pc_fetch_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_i        (stall),
        .redir_valid_i  (redir_v),
        .redir_target_i (redir_t),
        .imem           (bus.master),
        .if_valid_o     (if_valid),
        .if_pc_o        (if_pc),
        .if_instr_o     (if_instr),
        .flush_o        (flush),
        .misalign_o     (misalign),
        .pc_o           (pc)
    );

    pc_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk            (clk),
        .rst            (rst2),
        .stall_i        (stall2),
        .redir_valid_i  (redir_v2),
        .redir_target_i (redir_t2),
        .imem           (bus2.master),
        .if_valid_o     (if_valid2),
        .if_pc_o        (if_pc2),
        .if_instr_o     (if_instr2),
        .flush_o        (flush2),
        .misalign_o     (misalign2),
        .pc_o           (pc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        stall          = 1'b0;
        redir_v        = 1'b0;
        redir_t        = 32'h0;
        bus.imem_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst     = 1'b1;
        redir_v = 1'b1;
        redir_t = 32'h0000_0040;
        #1;
        total_cnt++;
        if (flush !== 1'b0) $display("FAIL reset_flush got=%b exp=0", flush);
        else pass_cnt++;
        step();
        total_cnt++;
        if (bus.imem_req !== 1'b0 || if_valid !== 1'b0 || if_pc !== 32'h0 ||
            if_instr !== 32'h0 || misalign !== 1'b0 || pc !== 32'h0)
            $display("FAIL reset_state got req=%b v=%b ifpc=%h instr=%h mis=%b pc=%h exp 0s",
                     bus.imem_req, if_valid, if_pc, if_instr, misalign, pc);
        else pass_cnt++;
        redir_v = 1'b0;
        rst     = 1'b0;
        step();
        total_cnt++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || if_valid !== 1'b0)
            $display("FAIL first_fetch got req=%b addr=%h v=%b exp req=1 addr=0 v=0",
                     bus.imem_req, bus.imem_addr, if_valid);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            step();
            total_cnt++;
            if (if_valid !== 1'b1 || if_pc !== 32'(i * 4) || if_instr !== (32'(i * 4) ^ KEY))
                $display("FAIL seq_%0d got v=%b pc=%h instr=%h exp v=1 pc=%h",
                         i, if_valid, if_pc, if_instr, 32'(i * 4));
            else pass_cnt++;
        end
    endtask

    task automatic test_stall();
        do_reset();
        step();             // IDLE -> FETCH
        step();             // deliver 0
        step();             // deliver 4, pc = 8
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            total_cnt++;
            if (pc !== 32'h8 || if_valid !== 1'b0)
                $display("FAIL stall_hold_%0d got pc=%h v=%b exp pc=8 v=0", i, pc, if_valid);
            else pass_cnt++;
        end
        stall = 1'b0;
        step();
        total_cnt++;
        if (if_valid !== 1'b1 || if_pc !== 32'h8)
            $display("FAIL stall_release got v=%b pc=%h exp v=1 pc=8", if_valid, if_pc);
        else pass_cnt++;
        step();
        total_cnt++;
        if (if_valid !== 1'b1 || if_pc !== 32'hC)
            $display("FAIL stall_next got v=%b pc=%h exp v=1 pc=c", if_valid, if_pc);
        else pass_cnt++;
        // pc is now 0x10
    endtask

    task automatic test_redirect();
        redir_v = 1'b1;
        redir_t = 32'h0000_0100;
        #1;
        total_cnt++;
        if (flush !== 1'b1) $display("FAIL redir_flush got=%b exp=1", flush);
        else pass_cnt++;
        step();
        redir_v = 1'b0;
        total_cnt++;
        if (if_valid !== 1'b0 || pc !== 32'h100 || misalign !== 1'b0)
            $display("FAIL redir_drop got v=%b pc=%h mis=%b exp v=0 pc=100 mis=0",
                     if_valid, pc, misalign);
        else pass_cnt++;
        step();
        total_cnt++;
        if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== (32'h100 ^ KEY))
            $display("FAIL redir_deliver got v=%b pc=%h instr=%h exp v=1 pc=100",
                     if_valid, if_pc, if_instr);
        else pass_cnt++;
        // pc is now 0x104; redirect beats a same-cycle stall
        stall   = 1'b1;
        redir_v = 1'b1;
        redir_t = 32'h0000_0180;
        step();
        stall   = 1'b0;
        redir_v = 1'b0;
        total_cnt++;
        if (pc !== 32'h180 || if_valid !== 1'b0)
            $display("FAIL redir_vs_stall got pc=%h v=%b exp pc=180 v=0", pc, if_valid);
        else pass_cnt++;
        step();     // deliver 0x180, pc = 0x184
    endtask

    task automatic test_drain();
        bus.imem_ready = 1'b0;
        redir_v        = 1'b1;
        redir_t        = 32'h0000_0200;
        #1;
        total_cnt++;
        if (flush !== 1'b1 || bus.imem_addr !== 32'h184)
            $display("FAIL drain_enter got flush=%b addr=%h exp flush=1 addr=184",
                     flush, bus.imem_addr);
        else pass_cnt++;
        step();
        redir_t = 32'h0000_0300;
        #1;
        total_cnt++;
        if (flush !== 1'b1) $display("FAIL drain_flush got=%b exp=1", flush);
        else pass_cnt++;
        step();
        redir_v = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total_cnt++;
            if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h184 || if_valid !== 1'b0 || pc !== 32'h184)
                $display("FAIL drain_wait_%0d got req=%b addr=%h v=%b exp req=1 addr=184 v=0",
                         i, bus.imem_req, bus.imem_addr, if_valid);
            else pass_cnt++;
            step();
        end
        bus.imem_ready = 1'b1;
        step();
        total_cnt++;
        if (bus.imem_addr !== 32'h300 || if_valid !== 1'b0)
            $display("FAIL drain_exit got addr=%h v=%b exp addr=300 v=0", bus.imem_addr, if_valid);
        else pass_cnt++;
        step();
        total_cnt++;
        if (if_valid !== 1'b1 || if_pc !== 32'h300)
            $display("FAIL drain_deliver got v=%b pc=%h exp v=1 pc=300", if_valid, if_pc);
        else pass_cnt++;
        // pc is now 0x304; same-cycle redirect and ready while draining
        bus.imem_ready = 1'b0;
        redir_v        = 1'b1;
        redir_t        = 32'h0000_0400;
        step();
        redir_t        = 32'h0000_0500;
        bus.imem_ready = 1'b1;
        step();
        redir_v = 1'b0;
        total_cnt++;
        if (pc !== 32'h500 || if_valid !== 1'b0)
            $display("FAIL drain_late_redir got pc=%h v=%b exp pc=500 v=0", pc, if_valid);
        else pass_cnt++;
        step();     // deliver 0x500, pc = 0x504
    endtask

    task automatic test_misalign();
        redir_v = 1'b1;
        redir_t = 32'h0000_0102;
        step();
        redir_v = 1'b0;
        total_cnt++;
        if (pc !== 32'h100 || misalign !== 1'b1)
            $display("FAIL misalign_pulse got pc=%h mis=%b exp pc=100 mis=1", pc, misalign);
        else pass_cnt++;
        step();
        total_cnt++;
        if (misalign !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h100)
            $display("FAIL misalign_end got mis=%b v=%b pc=%h exp mis=0 v=1 pc=100",
                     misalign, if_valid, if_pc);
        else pass_cnt++;
    endtask

    task automatic test_wrap();
        rst2 = 1'b1;
        step();
        step();
        rst2 = 1'b0;
        step();
        total_cnt++;
        if (bus2.imem_addr !== 32'hFFFF_FFFC || bus2.imem_req !== 1'b1)
            $display("FAIL wrap_first got addr=%h req=%b exp addr=fffffffc req=1",
                     bus2.imem_addr, bus2.imem_req);
        else pass_cnt++;
        step();
        total_cnt++;
        if (bus2.imem_addr !== 32'h0 || if_pc2 !== 32'hFFFF_FFFC || if_valid2 !== 1'b1)
            $display("FAIL wrap_second got addr=%h ifpc=%h v=%b exp addr=0 ifpc=fffffffc v=1",
                     bus2.imem_addr, if_pc2, if_valid2);
        else pass_cnt++;
        step();
        total_cnt++;
        if (if_pc2 !== 32'h0 || if_valid2 !== 1'b1)
            $display("FAIL wrap_deliver got ifpc=%h v=%b exp ifpc=0 v=1", if_pc2, if_valid2);
        else pass_cnt++;
    endtask

    task automatic test_reset_in_drain();
        bus.imem_ready = 1'b0;
        redir_v        = 1'b1;
        redir_t        = 32'h0000_0700;
        step();         // now in DRAIN
        redir_v = 1'b0;
        rst     = 1'b1;
        step();
        total_cnt++;
        if (bus.imem_req !== 1'b0 || if_valid !== 1'b0 || pc !== 32'h0)
            $display("FAIL rst_drain got req=%b v=%b pc=%h exp req=0 v=0 pc=0",
                     bus.imem_req, if_valid, pc);
        else pass_cnt++;
        bus.imem_ready = 1'b1;  // late response from the abandoned request
        step();
        rst = 1'b0;
        step();
        total_cnt++;
        if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || if_valid !== 1'b0)
            $display("FAIL rst_restart got req=%b addr=%h v=%b exp req=1 addr=0 v=0",
                     bus.imem_req, bus.imem_addr, if_valid);
        else pass_cnt++;
        step();
        total_cnt++;
        if (if_valid !== 1'b1 || if_pc !== 32'h0 || pc !== 32'h4)
            $display("FAIL rst_deliver got v=%b ifpc=%h pc=%h exp v=1 ifpc=0 pc=4",
                     if_valid, if_pc, pc);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt        = 0;
        total_cnt       = 0;
        rst             = 1'b1;
        stall           = 1'b0;
        redir_v         = 1'b0;
        redir_t         = 32'h0;
        bus.imem_ready  = 1'b0;
        rst2            = 1'b1;
        stall2          = 1'b0;
        redir_v2        = 1'b0;
        redir_t2        = 32'h0;
        bus2.imem_ready = 1'b1;

        test_reset();
        test_stall();
        test_redirect();
        test_drain();
        test_misalign();
        test_wrap();
        test_reset_in_drain();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
